// File: rtl/mux_scan_reg.sv
// Registered N-channel, W-bit multiplexer with a valid/ready output slot.
// Channels are picked from S (manual) or by a round-robin scan pointer that dwells DWELL samples per channel.
module mux_scan_reg #(
  parameter int W     = 8,
  parameter int N     = 8,
  parameter int SW    = 3,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  I,
  input  logic [SW-1:0]   S,
  input  logic            mode,
  input  logic            en,
  output logic [W-1:0]    O,
  output logic [SW-1:0]   O_ch,
  output logic            O_err,
  output logic            O_valid,
  input  logic            O_ready
);

  localparam int DW = $clog2(DWELL) + 1;

  logic [SW-1:0] ptr;
  logic [DW-1:0] dcnt;
  logic          mode_q;

  logic          free;
  logic          capture;
  logic          entry;
  logic [SW-1:0] ptr_eff;
  logic [DW-1:0] dcnt_eff;
  logic [SW-1:0] ch;
  logic [31:0]   ch_ext;
  logic          in_range;
  logic [W-1:0]  sel_data;

  // A fresh scan entry restarts at channel 0 in the same edge it is detected.
  always_comb begin
    free     = !O_valid || O_ready;
    capture  = en && free;
    entry    = mode && !mode_q;
    ptr_eff  = entry ? '0 : ptr;
    dcnt_eff = entry ? '0 : dcnt;
    ch       = mode ? ptr_eff : S;
    ch_ext   = 32'(ch);
    in_range = ch_ext < 32'(N);
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (ch == SW'(k)) sel_data = I[k*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O       <= '0;
      O_ch    <= '0;
      O_err   <= 1'b0;
      O_valid <= 1'b0;
      ptr     <= '0;
      dcnt    <= '0;
      mode_q  <= 1'b0;
    end else begin
      mode_q <= mode;

      if (capture) begin
        O       <= in_range ? sel_data : '0;
        O_ch    <= ch;
        O_err   <= !in_range;
        O_valid <= 1'b1;
      end else if (O_valid && O_ready) begin
        O_valid <= 1'b0;
      end

      // Scan position only moves on a scan capture; an entry without capture still rewinds it.
      if (capture && mode) begin
        if (dcnt_eff == DW'(DWELL - 1)) begin
          dcnt <= '0;
          ptr  <= (ptr_eff == SW'(N - 1)) ? '0 : ptr_eff + SW'(1);
        end else begin
          dcnt <= dcnt_eff + DW'(1);
          ptr  <= ptr_eff;
        end
      end else if (entry) begin
        ptr  <= '0;
        dcnt <= '0;
      end
    end
  end

endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with a valid/ready output handshake.
- Manual mode selects the channel from the S input.
- Auto-scan mode walks the channels round-robin, taking DWELL samples per channel.
- Sits between multi-channel sources (switch banks, sensor words, counters) and a single downstream consumer such as a display or UART formatter.

Parameters:
- W, 8: data width per channel.
- N, 8: number of channels, N >= 2.
- SW, 3: select width; 2^SW >= N is required.
- DWELL, 4: consecutive samples taken per channel in scan mode before advancing; DWELL >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- I  in  N*W  packed channel data; channel k occupies I[k*W+W-1 : k*W].
- S  in  SW  manual channel select.
- mode  in  1  0 = manual, 1 = auto-scan.
- en  in  1  capture enable.
- O  out  W  registered sample data.
- O_ch  out  SW  channel index the current sample came from.
- O_err  out  1  current sample used an out-of-range select.
- O_valid  out  1  sample held in O, O_ch and O_err is valid.
- O_ready  in  1  downstream accepts the sample.

Behaviour:
- Reset (async assert, sync-safe release):
  - O=0, O_ch=0, O_err=0, O_valid=0.
  - scan pointer ptr=0, dwell counter dcnt=0, registered mode mode_q=0.
  - Reset asserted mid-transfer drops O_valid immediately. No sample survives reset.
- Slot free: free = !O_valid || O_ready.
- Capture: occurs on a clk edge when en=1 and free=1.
  - ch = mode ? ptr : S.
  - O <= channel ch data, O_ch <= ch, O_valid <= 1.
  - Latency is one cycle: the value of I sampled at edge k is on O after edge k.
- Out-of-range: applies when ch >= N, which is reachable only through S when N < 2^SW.
  - O <= 0, O_err <= 1, O_ch <= ch, O_valid <= 1.
  - Never X.
  - O_err is cleared by the next capture that is in range.
- Drain: on an edge with O_valid=1, O_ready=1 and no capture (en=0), O_valid <= 0.
  - O, O_ch and O_err keep their last values.
- Backpressure: while O_valid=1 and O_ready=0:
  - O, O_ch and O_err are stable.
  - No capture occurs; ptr and dcnt are frozen.
  - Changes on I, S or mode are ignored until the stall clears, except for mode edge detection (below).
- Simultaneous accept and capture (O_valid=1, O_ready=1, en=1): the new sample replaces the old one in the same edge. O_valid stays 1. Full throughput is one sample per cycle.
- Scan sequencing (mode=1), on each capture:
  - If dcnt == DWELL-1: dcnt <= 0 and ptr <= (ptr == N-1) ? 0 : ptr+1.
  - Otherwise: dcnt <= dcnt+1.
  - ptr never reaches values >= N, so O_err is never set in scan mode.
- Mode entry: mode_q tracks mode every cycle.
  - A 0->1 transition (mode=1, mode_q=0) forces ptr=0 and dcnt=0 for that edge's capture decision; the capture in that cycle samples channel 0.
  - A 1->0 transition leaves ptr and dcnt unchanged but unused. They are reinitialised on the next scan entry.
- Manual mode: ptr and dcnt hold.
- State summary (derived from O_valid and the inputs):
  - EMPTY (O_valid=0).
  - FULL_WAIT (O_valid=1, O_ready=0).
  - FULL_FLOW (O_valid=1, O_ready=1).
  - Transitions follow the capture and drain rules above.
- Counter widths: ptr is SW bits; dcnt is clog2(DWELL)+1 bits. No arithmetic overflow is permitted.

Test Plan:
- Manual select, N=8, W=8, I=0x8070605040302010, mode=0, en=1, O_ready=1, S stepping 0..7 → O = 0x10, 0x20, … 0x80 one cycle after each S value; O_ch follows S; O_err=0.
- Backpressure: capture S=3 (O=0x40), then O_ready=0 for 5 cycles while S changes to 6 → O stays 0x40 and O_valid stays 1. O_ready=1 → the next edge loads 0x70.
- Scan wrap, N=4, DWELL=2, en=1, O_ready=1, mode 0→1 → O_ch sequence 0,0,1,1,2,2,3,3,0,0; no O_err.
- Out-of-range, N=6, SW=3, manual, S=7 → O=0, O_err=1, O_ch=7, O_valid=1. Then S=2 → O_err=0 and O = channel 2 data.
- Reset mid-scan: with ptr=2 and O_valid=1, pulse rst_n low asynchronously between clock edges → all outputs 0 immediately. After release with mode=1 held, the first capture is channel 0, since mode_q resets to 0 and entry is re-detected.
- Drain and idle: with O_valid=1, set en=0 and O_ready=1 → O_valid falls after one edge while O holds its value. With en=0 the block stays empty indefinitely and ptr does not advance.
